dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single data memory (DMem). It shares that memory between the CPU MEM-stage port (port 0) and a debug/loader port (port 1), for example a UART program loader or a switch-driven memory inspector. Each granted access runs through a fixed 3-state sequence with an ack handshake. The CPU stalls on `cpu_stall` until its access is acknowledged.

Parameters:
- ADDR_W, 32, byte-address width on both ports and on the memory side.
- DATA_W, 32, data width.

Ports:
- clk  in  1  CPU clock (the same clock as DMem).
- rstn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_amp  in  3  access unit size (funct3 encoding).
- cpu_wdata  in  DATA_W  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1.
- cpu_err  out  1  misaligned access; valid while cpu_ack=1.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- dbg_req, dbg_we, dbg_addr, dbg_amp, dbg_wdata, dbg_ack, dbg_rdata, dbg_err: same widths, directions and meaning as the cpu_* ports, for port 1.
- mem_re  out  1  DMem readEnable.
- mem_we  out  1  DMem writeEnable.
- mem_addr  out  ADDR_W  DMem address.
- mem_amp  out  3  DMem unitSize.
- mem_wdata  out  DATA_W  DMem writeData.
- mem_rdata  in  DATA_W  DMem readData (combinational read).

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner (priority rule below).
  - Latch the winner's we/addr/amp/wdata and its port id into internal registers; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS, exactly 1 cycle:
  - mem_addr/mem_amp/mem_wdata are driven from the latched registers.
  - mem_we = latched we & ~mis; mem_re = ~latched we & ~mis.
  - At the closing edge, capture mem_rdata into the winner's rdata register and mis into its err register; go to RESP.
- RESP, exactly 1 cycle:
  - The winner's ack = 1 with rdata/err valid. All reqs are ignored. Go to IDLE.
- Misalignment (mis):
  - Half access (amp[1:0]=01) with addr[0]=1 is misaligned.
  - Word access (amp[1:0]=10) with addr[1:0]≠00 is misaligned.
  - Byte access never is.
  - On mis: no memory strobe, rdata = 0, err = 1.
- Latency and throughput: an ack appears 2 cycles after the IDLE cycle in which req is sampled. Maximum throughput is 1 access per 3 cycles.
- Handshake rules:
  - Requester fields must be stable from the rise of req through the grant edge.
  - The requester deasserts req (or presents a new request) on the edge where it samples ack.
  - A req still high in the IDLE cycle after RESP is treated as a new access.
- Priority with both reqs high in IDLE: CPU wins (fixed priority), unless ARB_RR_EN is defined.
- The loser keeps req high and is served on the next IDLE cycle if it still wins.
- Outside ACCESS: mem_re = mem_we = 0. mem_addr/mem_amp/mem_wdata hold their latched values.
- rdata registers hold their last value after ack falls.
- Reset (asynchronous, also mid-operation):
  - State = IDLE, all latches = 0, last_winner = 1.
  - All ack/err = 0, rdata = 0, mem_re = mem_we = 0.
  - An in-flight access is abandoned; a write is never issued after reset assertion.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin. On a simultaneous request the winner is the port ≠ last_winner; last_winner updates on every grant. After reset the CPU wins first (last_winner = 1).
- Undefined: fixed CPU priority; the debug port can starve; the last_winner register is not built.

Decomposition:
- Shared package (in defines.v):
  - Unit-size constants: UNIT_B=3'b000, UNIT_H=3'b001, UNIT_W=3'b010, UNIT_BU=3'b100, UNIT_HU=3'b101.
  - FSM state encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
- Sub-module: align_check, a combinational addr/amp→mis checker, instantiated once on the latched request.

Test Plan:
- CPU write: cpu_req, we=1, addr=0x10, amp=UNIT_W, wdata=0xDEADBEEF → mem_we=1 for 1 cycle with those values; cpu_ack 2 cycles after the grant edge; cpu_stall=1 until then.
- CPU read-back of 0x10 → cpu_rdata=0xDEADBEEF with cpu_ack; cpu_err=0.
- Both reqs high from reset, held for two accesses → fixed priority: CPU, then dbg only after CPU drops req. With DMEM_ARB_RR_EN: CPU, dbg, CPU alternating.
- dbg word read at addr 0x12 → no mem_re/mem_we strobe; dbg_ack with dbg_err=1, dbg_rdata=0. Half read at 0x12 → err=0, strobe issued.
- rstn pulsed low during ACCESS of a write → mem_we falls immediately; no ack; the next request completes normally from IDLE.
- Back-to-back CPU reqs with req held high → one ack every 3 cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: access unit sizes and sequencer state encoding.
package dmem_arbiter_pkg;

    localparam logic [2:0] UNIT_B  = 3'b000;
    localparam logic [2:0] UNIT_H  = 3'b001;
    localparam logic [2:0] UNIT_W  = 3'b010;
    localparam logic [2:0] UNIT_BU = 3'b100;
    localparam logic [2:0] UNIT_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_align_check.sv
// Combinational misalignment detector for a latched request (address low bits vs unit size).
module dmem_arbiter_align_check (
    input  logic [1:0] addr_lo,
    input  logic [1:0] amp_lo,
    output logic       mis
);
    always_comb begin
        mis = 1'b0;
        unique case (amp_lo)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = |addr_lo;
            default: mis = 1'b0;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMem arbiter: CPU (port 0) and debug/loader (port 1), IDLE->ACCESS->RESP per access.
// Define DMEM_ARB_RR_EN for round-robin arbitration; fixed CPU priority otherwise.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_amp,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [2:0]        dbg_amp,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_amp,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    arb_state_e        state_q, state_d;
    logic              lat_we_q, lat_port_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [2:0]        lat_amp_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              cpu_err_q, dbg_err_q;
    logic              any_req, win, mis, grant;

    assign any_req = cpu_req | dbg_req;
    assign grant   = (state_q == StIdle) & any_req;

`ifdef DMEM_ARB_RR_EN
    logic last_winner_q;

    // On a tie the port that did not win last time is served.
    always_comb begin
        win = PORT_CPU;
        if (cpu_req && dbg_req) win = ~last_winner_q;
        else                    win = cpu_req ? PORT_CPU : PORT_DBG;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      last_winner_q <= PORT_DBG;
        else if (grant) last_winner_q <= win;
    end
`else
    always_comb begin
        win = cpu_req ? PORT_CPU : PORT_DBG;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_we_q    <= 1'b0;
            lat_port_q  <= PORT_CPU;
            lat_addr_q  <= '0;
            lat_amp_q   <= '0;
            lat_wdata_q <= '0;
        end else if (grant) begin
            lat_port_q  <= win;
            lat_we_q    <= (win == PORT_DBG) ? dbg_we    : cpu_we;
            lat_addr_q  <= (win == PORT_DBG) ? dbg_addr  : cpu_addr;
            lat_amp_q   <= (win == PORT_DBG) ? dbg_amp   : cpu_amp;
            lat_wdata_q <= (win == PORT_DBG) ? dbg_wdata : cpu_wdata;
        end
    end

    dmem_arbiter_align_check u_align_check (
        .addr_lo (lat_addr_q[1:0]),
        .amp_lo  (lat_amp_q[1:0]),
        .mis     (mis)
    );

    // Response registers are captured at the closing edge of ACCESS and held afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else if (state_q == StAccess) begin
            if (lat_port_q == PORT_DBG) begin
                dbg_rdata_q <= mis ? '0 : mem_rdata;
                dbg_err_q   <= mis;
            end else begin
                cpu_rdata_q <= mis ? '0 : mem_rdata;
                cpu_err_q   <= mis;
            end
        end
    end

    always_comb begin
        mem_we    = (state_q == StAccess) & lat_we_q & ~mis;
        mem_re    = (state_q == StAccess) & ~lat_we_q & ~mis;
        mem_addr  = lat_addr_q;
        mem_amp   = lat_amp_q;
        mem_wdata = lat_wdata_q;
        cpu_ack   = (state_q == StResp) & (lat_port_q == PORT_CPU);
        dbg_ack   = (state_q == StResp) & (lat_port_q == PORT_DBG);
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        cpu_err   = cpu_err_q;
        dbg_err   = dbg_err_q;
        cpu_stall = cpu_req & ~cpu_ack;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses against a small word-array memory model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic        clk, rstn;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_amp;
    logic        dbg_req, dbg_we, dbg_ack, dbg_err;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [2:0]  dbg_amp;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_amp;

    logic [31:0] tbmem [64];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    logic [31:0] last_we_addr, last_we_data;
    logic [2:0]  last_we_amp;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_amp   (cpu_amp),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_amp   (dbg_amp),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .dbg_err   (dbg_err),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_amp   (mem_amp),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tbmem[mem_addr[7:2]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) tbmem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ack(input bit port, input logic [31:0] rdata, input logic err);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: port %0d acked with nothing expected", port);
        end else begin
            e = exp_q.pop_front();
            check("ack_port", {31'b0, port}, {31'b0, e.port});
            check("ack_rdata", rdata, e.rdata);
            check("ack_err", {31'b0, err}, {31'b0, e.err});
        end
    endtask

    // Monitor: pops the scoreboard on every ack; counts memory strobes.
    always @(negedge clk) begin
        if (cpu_ack) check_ack(1'b0, cpu_rdata, cpu_err);
        if (dbg_ack) check_ack(1'b1, dbg_rdata, dbg_err);
        if (mem_we) begin
            we_cnt++;
            last_we_addr = mem_addr;
            last_we_data = mem_wdata;
            last_we_amp  = mem_amp;
        end
        if (mem_re) re_cnt++;
    end

    task automatic push_exp(input bit port, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [2:0] amp, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input bit exp_err);
        int n;
        bit got;
        push_exp(port, exp_rdata, exp_err);
        @(negedge clk);
        if (port) begin
            dbg_we = we; dbg_addr = addr; dbg_amp = amp; dbg_wdata = wdata; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_amp = amp; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = port ? dbg_ack : cpu_ack;
            if (!port && n == 1) check("stall_wait", {31'b0, cpu_stall}, 32'd1);
        end
        check("ack_latency", n, 32'd2);
        if (!port) check("stall_at_ack", {31'b0, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        int wc, rc, ncpu, n;
        bit dbg_done;
        int ack_cyc [3];
        for (int i = 0; i < 64; i++) tbmem[i] = 32'h0;
        rstn = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_amp = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_amp = 0; dbg_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
        check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_re", {31'b0, mem_re}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rstn = 1'b1;

        // CPU word write, then read-back
        wc = we_cnt;
        do_access(1'b0, 1'b1, 32'h10, UNIT_W, 32'hDEADBEEF, 32'h0, 1'b0);
        check("wr_strobe_cnt", we_cnt - wc, 32'd1);
        check("wr_strobe_addr", last_we_addr, 32'h10);
        check("wr_strobe_data", last_we_data, 32'hDEADBEEF);
        check("wr_strobe_amp", {29'b0, last_we_amp}, {29'b0, UNIT_W});
        rc = re_cnt;
        do_access(1'b0, 1'b0, 32'h10, UNIT_W, 32'h0, 32'hDEADBEEF, 1'b0);
        check("rd_strobe_cnt", re_cnt - rc, 32'd1);

        // Misaligned word read: no strobe; aligned half read at same address does strobe
        wc = we_cnt; rc = re_cnt;
        do_access(1'b1, 1'b0, 32'h12, UNIT_W, 32'h0, 32'h0, 1'b1);
        check("mis_no_re", re_cnt - rc, 32'd0);
        check("mis_no_we", we_cnt - wc, 32'd0);
        do_access(1'b1, 1'b0, 32'h12, UNIT_H, 32'h0, 32'hDEADBEEF, 1'b0);
        check("half_re", re_cnt - rc, 32'd1);

        do_access(1'b0, 1'b1, 32'h20, UNIT_W, 32'h12345678, 32'h0, 1'b0);
        do_access(1'b1, 1'b1, 32'h30, UNIT_W, 32'hCAFEF00D, 32'h0, 1'b0);
        check("dbg_wr_addr", last_we_addr, 32'h30);

        // Both ports requesting; CPU keeps req high for two accesses
`ifdef DMEM_ARB_RR_EN
        push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        push_exp(1'b1, 32'hCAFEF00D, 1'b0);
        push_exp(1'b0, 32'h12345678, 1'b0);
`else
        push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        push_exp(1'b0, 32'h12345678, 1'b0);
        push_exp(1'b1, 32'hCAFEF00D, 1'b0);
`endif
        @(negedge clk);
        cpu_we = 0; cpu_addr = 32'h10; cpu_amp = UNIT_W; cpu_req = 1'b1;
        dbg_we = 0; dbg_addr = 32'h30; dbg_amp = UNIT_W; dbg_req = 1'b1;
        ncpu = 0; dbg_done = 1'b0; n = 0;
        while ((ncpu < 2 || !dbg_done) && n < 30) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin
                ncpu++;
                if (ncpu == 1) cpu_addr = 32'h20;
                else cpu_req = 1'b0;
            end
            if (dbg_ack) begin
                dbg_done = 1'b1;
                dbg_req = 1'b0;
            end
        end
        check("both_done_cycles", n, 32'd8);
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Back-to-back CPU reads with req held high
        for (int i = 0; i < 3; i++) push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        cpu_we = 0; cpu_addr = 32'h10; cpu_amp = UNIT_W; cpu_req = 1'b1;
        ncpu = 0; n = 0;
        while (ncpu < 3 && n < 20) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin
                ack_cyc[ncpu] = cyc;
                ncpu++;
            end
        end
        cpu_req = 1'b0;
        check("b2b_count", ncpu, 32'd3);
        check("b2b_gap1", ack_cyc[1] - ack_cyc[0], 32'd3);
        check("b2b_gap2", ack_cyc[2] - ack_cyc[1], 32'd3);

        // Reset asserted while a write is in ACCESS
        @(negedge clk);
        cpu_we = 1; cpu_addr = 32'h40; cpu_amp = UNIT_W; cpu_wdata = 32'h55AA55AA; cpu_req = 1'b1;
        @(negedge clk);
        check("abort_we_before", {31'b0, mem_we}, 32'd1);
        #1 rstn = 1'b0;
        #1 check("abort_we_after", {31'b0, mem_we}, 32'd0);
        check("abort_rdata_clr", cpu_rdata, 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write", tbmem[16], 32'h0);
        do_access(1'b0, 1'b0, 32'h40, UNIT_W, 32'h0, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
